// File: rtl/shift_pkg.sv
// Shared op encoding and op classification helpers for the barrel shift unit.
package shift_pkg;

  typedef logic [2:0] op_t;

  localparam op_t OP_SLL = 3'b000;
  localparam op_t OP_SRL = 3'b010;
  localparam op_t OP_SRA = 3'b011;
  localparam op_t OP_ROL = 3'b100;
  localparam op_t OP_ROR = 3'b101;

  function automatic logic is_left(input op_t op);
    return (op == OP_SLL) || (op == OP_ROL);
  endfunction

  function automatic logic is_rot(input op_t op);
    return (op == OP_ROL) || (op == OP_ROR);
  endfunction

  function automatic logic is_legal(input op_t op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA) ||
           (op == OP_ROL) || (op == OP_ROR);
  endfunction

endpackage

// File: rtl/shift_stage.sv
// One pipeline stage: COUNT right-shift mux levels starting at weight 2**FIRST,
// followed by the stage register (data, op, residual shamt, valid).
module shift_stage
  import shift_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5,
  parameter int FIRST   = 0,
  parameter int COUNT   = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               in_valid,
  input  logic [DATA_W-1:0]  in_data,
  input  op_t                in_op,
  input  logic [SHAMT_W-1:0] in_shamt,
  output logic               valid,
  output logic [DATA_W-1:0]  data,
  output op_t                op,
  output logic [SHAMT_W-1:0] shamt
);

  // shamt bits consumed here are cleared so the register holds only the residual
  localparam logic [SHAMT_W-1:0] USED = SHAMT_W'(((64'd1 << COUNT) - 64'd1) << FIRST);

  logic [DATA_W-1:0] lvl [COUNT+1];

  assign lvl[0] = in_data;

  for (genvar j = 0; j < COUNT; j++) begin : g_level
    localparam int W = 1 << (FIRST + j);
    logic fill;
    // SRA keeps replicating the current MSB, which is still the original sign
    assign fill = (in_op == OP_SRA) && lvl[j][DATA_W-1];
    assign lvl[j+1] = !in_shamt[FIRST+j] ? lvl[j] :
                      is_rot(in_op)      ? {lvl[j][W-1:0], lvl[j][DATA_W-1:W]} :
                                           {{W{fill}}, lvl[j][DATA_W-1:W]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
      op    <= OP_SLL;
      shamt <= '0;
    end else if (load) begin
      valid <= in_valid;
      data  <= lvl[COUNT];
      op    <= in_op;
      shamt <= in_shamt & ~USED;
    end
  end

endmodule

// File: rtl/shift_unit.sv
// Pipelined barrel shifter/rotator: left ops are bit-reversed around a
// right-shift datapath whose mux levels are spread over PIPE stages.
module shift_unit
  import shift_pkg::*;
#(
  parameter  int DATA_W  = 32,
  parameter  int PIPE    = 2,
  localparam int SHAMT_W = $clog2(DATA_W)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         op,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [DATA_W-1:0]  data_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  data_out,
  output logic               op_err
);

  localparam int LEVELS = SHAMT_W;
  localparam int LPS    = (LEVELS + PIPE - 1) / PIPE;

  function automatic logic [DATA_W-1:0] bit_rev(input logic [DATA_W-1:0] x);
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W; i++) r[i] = x[DATA_W-1-i];
    return r;
  endfunction

  // Index 0 is the unit input; index k+1 is the register of stage k.
  logic [PIPE:0]      v;
  logic [DATA_W-1:0]  d [PIPE+1];
  op_t                o [PIPE+1];
  logic [SHAMT_W-1:0] s [PIPE+1];
  logic [PIPE:0]      rdy;
  logic [DATA_W-1:0]  entry_data;

  // Illegal ops enter as zero so every level keeps them zero.
  always_comb begin
    entry_data = '0;
    if (is_legal(op)) entry_data = is_left(op) ? bit_rev(data_in) : data_in;
  end

  assign v[0] = in_valid;
  assign d[0] = entry_data;
  assign o[0] = op;
  assign s[0] = shamt;

  // Valid/ready: a transfer happens on a rising edge where both are 1; a
  // stage loads when it is empty or its successor loads (last: out_ready).
  always_comb begin
    rdy       = '0;
    rdy[PIPE] = out_ready;
    for (int k = PIPE - 1; k >= 0; k--) rdy[k] = !v[k+1] || rdy[k+1];
  end

  for (genvar k = 0; k < PIPE; k++) begin : g_stage
    localparam int FIRST = k * LPS;
    localparam int REM   = LEVELS - FIRST;
    localparam int COUNT = (REM <= 0) ? 0 : ((REM < LPS) ? REM : LPS);

    shift_stage #(
      .DATA_W (DATA_W),
      .SHAMT_W(SHAMT_W),
      .FIRST  (FIRST),
      .COUNT  (COUNT)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .load    (rdy[k]),
      .in_valid(v[k]),
      .in_data (d[k]),
      .in_op   (o[k]),
      .in_shamt(s[k]),
      .valid   (v[k+1]),
      .data    (d[k+1]),
      .op      (o[k+1]),
      .shamt   (s[k+1])
    );
  end

  assign in_ready  = rdy[0];
  assign out_valid = v[PIPE];
  assign data_out  = is_left(o[PIPE]) ? bit_rev(d[PIPE]) : d[PIPE];
  assign op_err    = v[PIPE] && !is_legal(o[PIPE]);

endmodule

// File: tb/tb_shift_unit.sv
// Directed + random bench for shift_unit at 32/2 (unit a) and 8/3 (unit b).
module tb_shift_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  logic        a_in_valid = 1'b0, a_in_ready, a_out_valid, a_out_ready = 1'b0, a_op_err;
  logic [2:0]  a_op = 3'b000;
  logic [4:0]  a_shamt = '0;
  logic [31:0] a_data_in = '0, a_data_out;

  logic        b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b0, b_op_err;
  logic [2:0]  b_op = 3'b000;
  logic [2:0]  b_shamt = '0;
  logic [7:0]  b_data_in = '0, b_data_out;

  shift_unit #(.DATA_W(32), .PIPE(2)) u_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .op(a_op),
    .shamt(a_shamt), .data_in(a_data_in), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .data_out(a_data_out), .op_err(a_op_err)
  );

  shift_unit #(.DATA_W(8), .PIPE(3)) u_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .op(b_op),
    .shamt(b_shamt), .data_in(b_data_in), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .data_out(b_data_out), .op_err(b_op_err)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic acc_a, acc_b;
  logic [32:0] exp_a[$];
  logic [8:0]  exp_b[$];
  int pop_cyc[$];

  // Reference: {op_err, result} computed arithmetically for width w.
  function automatic logic [32:0] model(input int w, input logic [2:0] op, input int s,
                                        input logic [31:0] d);
    logic [63:0] m, x, r;
    m = (64'd1 << w) - 64'd1;
    x = {32'd0, d} & m;
    case (op)
      3'b000: r = (x << s) & m;
      3'b010: r = x >> s;
      3'b011: begin
        r = x >> s;
        if (x[w-1]) r = r | (m & ~(m >> s));
      end
      3'b100: r = ((x << s) | (x >> (w - s))) & m;
      3'b101: r = ((x >> s) | (x << (w - s))) & m;
      default: return {1'b1, 32'd0};
    endcase
    return {1'b0, r[31:0]};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: scoreboard both units at the negedge, return 1 time unit past posedge.
  task automatic tick();
    logic [32:0] m;
    acc_a = 1'b0;
    acc_b = 1'b0;
    @(negedge clk);
    if (!rst) begin
      if (a_in_valid && a_in_ready) begin
        exp_a.push_back(model(32, a_op, int'(a_shamt), a_data_in));
        acc_a = 1'b1;
      end
      if (b_in_valid && b_in_ready) begin
        m = model(8, b_op, int'(b_shamt), {24'd0, b_data_in});
        exp_b.push_back({m[32], m[7:0]});
        acc_b = 1'b1;
      end
      if (a_out_valid && a_out_ready) begin
        pop_cyc.push_back(cyc);
        if (exp_a.size() == 0) check("a_spurious", 64'(a_out_valid), 64'd0);
        else check("a_result", {31'd0, a_op_err, a_data_out}, 64'(exp_a.pop_front()));
      end
      if (b_out_valid && b_out_ready) begin
        if (exp_b.size() == 0) check("b_spurious", 64'(b_out_valid), 64'd0);
        else check("b_result", {55'd0, b_op_err, b_data_out}, 64'(exp_b.pop_front()));
      end
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic rand_a();
    a_op      = 3'($urandom_range(0, 7));
    a_shamt   = 5'($urandom_range(0, 31));
    a_data_in = $urandom;
  endtask

  task automatic send_wait(input string tag, input logic [2:0] op, input int s,
                           input logic [31:0] d, input logic [31:0] exp_d, input logic exp_e);
    a_op = op; a_shamt = 5'(s); a_data_in = d; a_in_valid = 1'b1; a_out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (acc_a) break;
    end
    a_in_valid = 1'b0;
    for (int i = 0; i < 10 && !a_out_valid; i++) tick();
    check({tag, "_valid"}, 64'(a_out_valid), 64'd1);
    check({tag, "_data"}, 64'(a_data_out), 64'(exp_d));
    check({tag, "_err"}, 64'(a_op_err), 64'(exp_e));
    tick();
  endtask

  task automatic drain();
    a_in_valid = 1'b0; b_in_valid = 1'b0;
    a_out_ready = 1'b1; b_out_ready = 1'b1;
    for (int i = 0; i < 50 && (exp_a.size() != 0 || exp_b.size() != 0); i++) tick();
    check("a_drained", 64'(exp_a.size()), 64'd0);
    check("b_drained", 64'(exp_b.size()), 64'd0);
  endtask

  initial begin
    int n0;
    logic [31:0] held;
    logic [2:0] legal_ops [5];
    legal_ops = '{3'b000, 3'b010, 3'b011, 3'b100, 3'b101};

    // Reset: requests presented meanwhile must be ignored.
    a_in_valid = 1'b1; b_in_valid = 1'b1; a_out_ready = 1'b1; b_out_ready = 1'b1;
    a_data_in = 32'hDEADBEEF; b_data_in = 8'hA5;
    repeat (3) @(posedge clk);
    #1;
    check("rst_a_out_valid", 64'(a_out_valid), 64'd0);
    check("rst_a_data_out", 64'(a_data_out), 64'd0);
    check("rst_a_op_err", 64'(a_op_err), 64'd0);
    check("rst_a_in_ready", 64'(a_in_ready), 64'd1);
    check("rst_b_out_valid", 64'(b_out_valid), 64'd0);
    check("rst_b_in_ready", 64'(b_in_ready), 64'd1);
    b_in_valid = 1'b0;

    // First request right after release: SRA latency is exactly two cycles.
    rst = 1'b0;
    a_op = 3'b011; a_shamt = 5'd4; a_data_in = 32'h8000_0000;
    tick();
    check("first_accept", 64'(acc_a), 64'd1);
    a_in_valid = 1'b0;
    check("lat_cycle1_valid", 64'(a_out_valid), 64'd0);
    tick();
    check("lat_cycle2_valid", 64'(a_out_valid), 64'd1);
    check("sra_data", 64'(a_data_out), 64'h0000_0000_F800_0000);
    tick();

    send_wait("rol8", 3'b100, 8, 32'h1234_5678, 32'h3456_7812, 1'b0);
    send_wait("ror8", 3'b101, 8, 32'h1234_5678, 32'h7812_3456, 1'b0);
    send_wait("sll31", 3'b000, 31, 32'h0000_0001, 32'h8000_0000, 1'b0);
    send_wait("illegal", 3'b111, 5, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);

    // Eight back-to-back accepts must leave on consecutive cycles.
    n0 = pop_cyc.size();
    a_out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rand_a();
      a_op = legal_ops[$urandom_range(0, 4)];
      a_in_valid = 1'b1;
      check("b2b_in_ready", 64'(a_in_ready), 64'd1);
      tick();
    end
    a_in_valid = 1'b0;
    for (int i = 0; i < 10 && pop_cyc.size() < n0 + 8; i++) tick();
    check("b2b_count", 64'(pop_cyc.size() - n0), 64'd8);
    if (pop_cyc.size() >= n0 + 8)
      check("b2b_span", 64'(pop_cyc[n0+7] - pop_cyc[n0]), 64'd7);

    // Fill with out_ready low, then stall five cycles.
    a_out_ready = 1'b0;
    rand_a();
    a_in_valid = 1'b1;
    for (int i = 0; i < 10 && a_in_ready; i++) begin
      tick();
      if (acc_a) rand_a();
    end
    check("stall_full", 64'(a_in_ready), 64'd0);
    held = a_data_out;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_in_ready", 64'(a_in_ready), 64'd0);
      check("stall_valid", 64'(a_out_valid), 64'd1);
      check("stall_data", 64'(a_data_out), 64'(held));
    end
    a_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (acc_a) rand_a();
    end
    drain();

    // Random traffic with all op codes and random backpressure.
    for (int i = 0; i < 300; i++) begin
      if (!a_in_valid || acc_a) begin
        a_in_valid = ($urandom_range(0, 3) != 0);
        rand_a();
      end
      a_out_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    drain();

    // Reset pulsed mid-flight discards both requests at once.
    a_out_ready = 1'b0;
    rand_a();
    a_in_valid = 1'b1;
    n0 = 0;
    for (int i = 0; i < 10 && n0 < 2; i++) begin
      tick();
      if (acc_a) begin
        n0++;
        rand_a();
      end
    end
    a_in_valid = 1'b0;
    check("mid_inflight", 64'(exp_a.size()), 64'd2);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 64'(a_out_valid), 64'd0);
    check("mid_rst_in_ready", 64'(a_in_ready), 64'd1);
    exp_a.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    a_out_ready = 1'b1;
    n0 = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (a_out_valid) n0++;
    end
    check("mid_rst_no_stale", 64'(n0), 64'd0);

    // Unit b: every legal op at every shift amount, two operands each.
    b_out_ready = 1'b1;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 5; k++) begin
        for (int s = 0; s < 8; s++) begin
          b_op = legal_ops[k];
          b_shamt = 3'(s);
          b_data_in = (r == 0) ? 8'h81 : 8'($urandom_range(0, 255));
          b_in_valid = 1'b1;
          for (int i = 0; i < 5; i++) begin
            tick();
            if (acc_b) break;
          end
        end
      end
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_unit.md
SHIFT_UNIT -- requirements
Module: shift_unit

Interface
REQ-001 Parameter DATA_W, default 32, operand width; SHALL be a power of two, 8..64.
REQ-002 Parameter PIPE, default 2, register stages; SHALL be 1..log2(DATA_W).
REQ-003 Localparam SHAMT_W = log2(DATA_W); it SHALL NOT be overridable.
REQ-004 clk  in  1  single clock, rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 in_valid  in  1  request present.
REQ-007 in_ready  out  1  unit accepts the request this cycle.
REQ-008 op  in  3  operation: 000 SLL, 010 SRL, 011 SRA, 100 ROL, 101 ROR; all other codes are illegal.
REQ-009 shamt  in  SHAMT_W  shift amount.
REQ-010 data_in  in  DATA_W  operand.
REQ-011 out_valid  out  1  result present.
REQ-012 out_ready  in  1  consumer takes the result this cycle.
REQ-013 data_out  out  DATA_W  result.
REQ-014 op_err  out  1  result came from an illegal op; qualified by out_valid.

Function
REQ-015 A request SHALL be accepted on a rising edge where in_valid && in_ready; a result SHALL be consumed where out_valid && out_ready.
REQ-016 SLL SHALL zero-fill from the LSB; SRL SHALL zero-fill from the MSB; SRA SHALL fill with data_in[DATA_W-1].
REQ-017 ROL and ROR SHALL rotate modulo DATA_W; shamt=0 SHALL return data_in unchanged for every legal op.
REQ-018 An illegal op SHALL produce data_out=0 with op_err=1; it SHALL still occupy one pipeline slot and obey the handshake.
REQ-019 The log2(DATA_W) mux levels (weights 1,2,4,...) SHALL be split across PIPE stages, with ceil(levels/PIPE) levels per stage and the remainder in the last stage; each stage SHALL register data, op, residual shamt and a valid bit.
REQ-020 Left operations SHALL be implemented by a bit-reversal at stage entry and exit around a right-shift datapath; both reversals SHALL be combinational and add no latency.
REQ-021 Latency SHALL be exactly PIPE cycles from acceptance to out_valid when not stalled; throughput SHALL be one result per cycle.
REQ-022 Stage k SHALL advance when stage k+1 is empty or advancing; the last stage SHALL advance when out_ready=1.
REQ-023 in_ready SHALL be 1 when stage 0 is empty or advancing; in_ready may depend combinationally on out_ready (no skid buffer).
REQ-024 When the pipeline is full and out_ready=0, all stages SHALL hold; data_out, op_err and out_valid SHALL remain stable until consumed.
REQ-025 Accept and consume in the same cycle with the pipeline full SHALL proceed with no bubble.
REQ-026 Results SHALL leave in acceptance order; no request SHALL be dropped or duplicated.

Reset
REQ-027 While rst=1, all valid bits, out_valid, op_err and data_out SHALL be 0.
REQ-028 in_ready SHALL be 1 during reset; requests presented during reset SHALL be ignored.
REQ-029 rst asserted mid-operation SHALL discard all in-flight requests immediately, without waiting for a clock edge.
REQ-030 The first accept SHALL occur at the first rising edge after rst deasserts.

Structure
REQ-031 Package shift_pkg SHALL hold the op encoding constants (OP_SLL, OP_SRL, OP_SRA, OP_ROL, OP_ROR) and an is_left(op) function.
REQ-032 One sub-module, shift_stage, SHALL implement a parametrised run of right-shift mux levels plus its pipeline register; shift_unit SHALL instantiate PIPE of them.

Verification
REQ-033 DATA_W=32, PIPE=2: SRA 0x80000000 by 4 -> 0xF8000000 exactly 2 cycles after accept.
REQ-034 ROL 0x12345678 by 8 -> 0x34567812; ROR of the same value by 8 -> 0x78123456; SLL 0x1 by 31 -> 0x80000000.
REQ-035 Back-to-back accepts of 8 requests with out_ready=1 -> 8 results on consecutive cycles, in order.
REQ-036 out_ready held 0 for 5 cycles with a full pipeline -> in_ready=0, data_out stable; on release, no request lost.
REQ-037 op=111 with data 0xFFFFFFFF -> data_out=0, op_err=1; rst pulsed with 2 in flight -> out_valid=0 immediately, no stale result after reset.
REQ-038 DATA_W=8, PIPE=3: exhaustive shamt 0..7 for all five legal ops against a reference model -> all match.
